// File: rtl/edge_window_counter_if.sv
// Measurement bus between the edge counter and its driver/consumer.
// Carries the run/ack controls, the raw gate outputs and the published window result.
interface edge_window_counter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             y1;
    logic             y2;
    logic             ack;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic             ovf1;
    logic             ovf2;
    logic             valid;
    logic             busy;

    modport master (
        output en, y1, y2, ack,
        input  cnt1, cnt2, ovf1, ovf2, valid, busy
    );

    modport slave (
        input  en, y1, y2, ack,
        output cnt1, cnt2, ovf1, ovf2, valid, busy
    );
endinterface

// File: rtl/edge_window_counter.sv
// Counts synchronized rising edges on y1/y2 over a fixed window of clock cycles
// and presents the two counts through a valid/ack handshake.
module edge_window_counter #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WIN_W  = 16,
    parameter int unsigned WINDOW = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    edge_window_counter_if.slave  bus
);

    localparam logic [CNT_W-1:0] ACC_MAX  = '1;
    localparam logic [WIN_W-1:0] TMR_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [1:0]       s1, s2, p;
    logic [1:0]       edge_c;
    logic [CNT_W-1:0] acc1, acc2, acc1_d, acc2_d, acc1_n, acc2_n;
    logic             sat1, sat2, sat1_d, sat2_d, sat1_n, sat2_n;
    logic [WIN_W-1:0] tmr, tmr_d;
    logic [CNT_W-1:0] cnt1_q, cnt2_q, cnt1_d, cnt2_d;
    logic             ovf1_q, ovf2_q, ovf1_d, ovf2_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    // Saturating increment: returns {sticky flag, accumulator}.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] a,
                                            input logic s, input logic e);
        logic             hit_max;
        logic [CNT_W-1:0] a_n;
        hit_max = e && (a == ACC_MAX);
        a_n     = (e && (a != ACC_MAX)) ? a + CNT_W'(1) : a;
        return {s | hit_max, a_n};
    endfunction

    // Synchronizer and history flops run regardless of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
            p  <= 2'b00;
        end else begin
            s1 <= {bus.y2, bus.y1};
            s2 <= s1;
            p  <= s2;
        end
    end

    assign edge_c = s2 & ~p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc1    <= '0;
            acc2    <= '0;
            sat1    <= 1'b0;
            sat2    <= 1'b0;
            tmr     <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            ovf1_q  <= 1'b0;
            ovf2_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            acc1    <= acc1_d;
            acc2    <= acc2_d;
            sat1    <= sat1_d;
            sat2    <= sat2_d;
            tmr     <= tmr_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            ovf1_q  <= ovf1_d;
            ovf2_q  <= ovf2_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        acc1_d  = acc1;
        acc2_d  = acc2;
        sat1_d  = sat1;
        sat2_d  = sat2;
        tmr_d   = tmr;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        ovf1_d  = ovf1_q;
        ovf2_d  = ovf2_q;
        valid_d = valid_q;
        {sat1_n, acc1_n} = bump(acc1, sat1, edge_c[0]);
        {sat2_n, acc2_n} = bump(acc2, sat2, edge_c[1]);

        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_d = COUNT;
                    acc1_d  = '0;
                    acc2_d  = '0;
                    sat1_d  = 1'b0;
                    sat2_d  = 1'b0;
                    tmr_d   = '0;
                end
            end
            COUNT: begin
                // Abort takes priority over completing the window.
                if (!bus.en) begin
                    state_d = IDLE;
                end else begin
                    tmr_d  = tmr + WIN_W'(1);
                    acc1_d = acc1_n;
                    acc2_d = acc2_n;
                    sat1_d = sat1_n;
                    sat2_d = sat2_n;
                    if (tmr == TMR_LAST) begin
                        state_d = HOLD;
                        cnt1_d  = acc1_n;
                        cnt2_d  = acc2_n;
                        ovf1_d  = sat1_n;
                        ovf2_d  = sat2_n;
                        valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    valid_d = 1'b0;
                    if (bus.en) begin
                        state_d = COUNT;
                        acc1_d  = '0;
                        acc2_d  = '0;
                        sat1_d  = 1'b0;
                        sat2_d  = 1'b0;
                        tmr_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == COUNT);
    end

    assign bus.cnt1  = cnt1_q;
    assign bus.cnt2  = cnt2_q;
    assign bus.ovf1  = ovf1_q;
    assign bus.ovf2  = ovf2_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_edge_window_counter.sv
// Directed bench for edge_window_counter: three instances cover the default-width
// window, a narrow saturating counter and the single-cycle window.
module tb_edge_window_counter;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   start;
    int   took;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    edge_window_counter_if #(.CNT_W(8)) bus_a ();
    edge_window_counter_if #(.CNT_W(4)) bus_b ();
    edge_window_counter_if #(.CNT_W(8)) bus_c ();

    edge_window_counter #(.CNT_W(8), .WIN_W(16), .WINDOW(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    edge_window_counter #(.CNT_W(4), .WIN_W(16), .WINDOW(128)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );
    edge_window_counter #(.CNT_W(8), .WIN_W(16), .WINDOW(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_y(input int b, input int ch, input logic v);
        case (b)
            0: if (ch == 1) bus_a.y1 = v; else bus_a.y2 = v;
            1: if (ch == 1) bus_b.y1 = v; else bus_b.y2 = v;
            default: if (ch == 1) bus_c.y1 = v; else bus_c.y2 = v;
        endcase
    endtask

    function automatic logic get_valid(input int b);
        case (b)
            0: return bus_a.valid;
            1: return bus_b.valid;
            default: return bus_c.valid;
        endcase
    endfunction

    task automatic pulses(input int b, input int ch, input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            set_y(b, ch, 1'b1);
            step(hi);
            set_y(b, ch, 1'b0);
            step(lo);
        end
    endtask

    // Returns clock edges from t0 until valid is first seen, or -1 on timeout.
    task automatic wait_valid(input int b, input int t0, input int limit, output int n);
        n = -1;
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (get_valid(b)) begin
                n = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus_a.en = 0; bus_a.y1 = 0; bus_a.y2 = 0; bus_a.ack = 0;
        bus_b.en = 0; bus_b.y1 = 0; bus_b.y2 = 0; bus_b.ack = 0;
        bus_c.en = 0; bus_c.y1 = 0; bus_c.y2 = 0; bus_c.ack = 0;
        step(3);
        check("rst_cnt1", int'(bus_a.cnt1), 0);
        check("rst_valid", int'(bus_a.valid), 0);
        check("rst_busy", int'(bus_a.busy), 0);
        check("rst_ovf1", int'(bus_a.ovf1), 0);
        rst_n = 1'b1;
        step(2);

        // Saturation: 20 edges into a 4-bit counter.
        start = cyc;
        bus_b.en = 1;
        step(1);
        pulses(1, 2, 20, 2, 4);
        wait_valid(1, start, 20, took);
        check("sat_latency", took, 129);
        check("sat_cnt2", int'(bus_b.cnt2), 15);
        check("sat_ovf2", int'(bus_b.ovf2), 1);
        check("sat_cnt1", int'(bus_b.cnt1), 0);
        check("sat_ovf1", int'(bus_b.ovf1), 0);
        bus_b.ack = 1; bus_b.en = 0;
        step(1);
        bus_b.ack = 0;
        check("sat_ack_valid", int'(bus_b.valid), 0);
        check("sat_ack_busy", int'(bus_b.busy), 0);

        // Basic count: five pulses on y1 in a 64-cycle window.
        start = cyc;
        bus_a.en = 1;
        step(1);
        check("basic_busy", int'(bus_a.busy), 1);
        step(1);
        pulses(0, 1, 5, 2, 4);
        wait_valid(0, start, 60, took);
        check("basic_latency", took, 65);
        check("basic_cnt1", int'(bus_a.cnt1), 5);
        check("basic_cnt2", int'(bus_a.cnt2), 0);
        check("basic_ovf1", int'(bus_a.ovf1), 0);
        check("basic_ovf2", int'(bus_a.ovf2), 0);
        check("hold_busy", int'(bus_a.busy), 0);

        // Handshake: no ack for 10 cycles while y1 keeps pulsing.
        pulses(0, 1, 2, 2, 3);
        check("hold_valid", int'(bus_a.valid), 1);
        check("hold_cnt1", int'(bus_a.cnt1), 5);
        bus_a.ack = 1;
        step(1);
        bus_a.ack = 0;
        check("ack_valid", int'(bus_a.valid), 0);
        check("ack_busy", int'(bus_a.busy), 1);
        check("ack_cnt1", int'(bus_a.cnt1), 5);

        // Abort at tmr=30 after three edges.
        pulses(0, 1, 3, 2, 4);
        step(12);
        bus_a.en = 0;
        step(1);
        check("abort_busy", int'(bus_a.busy), 0);
        check("abort_valid", int'(bus_a.valid), 0);
        check("abort_cnt1", int'(bus_a.cnt1), 5);
        step(3);
        check("abort_idle", int'(bus_a.busy), 0);

        // ack while valid=0 is ignored.
        bus_a.ack = 1;
        step(1);
        bus_a.ack = 0;
        check("stray_ack_valid", int'(bus_a.valid), 0);
        check("stray_ack_busy", int'(bus_a.busy), 0);
        check("stray_ack_cnt1", int'(bus_a.cnt1), 5);

        // y1 held high across the whole window.
        bus_a.y1 = 1;
        step(4);
        start = cyc;
        bus_a.en = 1;
        wait_valid(0, start, 80, took);
        check("high_latency", took, 65);
        check("high_cnt1", int'(bus_a.cnt1), 0);
        bus_a.ack = 1; bus_a.en = 0;
        step(1);
        bus_a.ack = 0;
        bus_a.y1 = 0;
        step(4);

        // Single-cycle window, simultaneous rises, then back-to-back with inputs held high.
        bus_c.y1 = 1; bus_c.y2 = 1;
        step(1);
        bus_c.en = 1;
        step(1);
        check("w1_busy", int'(bus_c.busy), 1);
        check("w1_valid_early", int'(bus_c.valid), 0);
        step(1);
        check("w1_valid", int'(bus_c.valid), 1);
        check("w1_cnt1", int'(bus_c.cnt1), 1);
        check("w1_cnt2", int'(bus_c.cnt2), 1);
        check("w1_hold_busy", int'(bus_c.busy), 0);
        bus_c.ack = 1;
        step(1);
        bus_c.ack = 0;
        check("b2b_valid", int'(bus_c.valid), 0);
        check("b2b_busy", int'(bus_c.busy), 1);
        step(1);
        check("b2b_valid2", int'(bus_c.valid), 1);
        check("b2b_cnt1", int'(bus_c.cnt1), 0);
        check("b2b_cnt2", int'(bus_c.cnt2), 0);
        bus_c.ack = 1; bus_c.en = 0;
        step(1);
        bus_c.ack = 0;

        // Fresh window after the abort starts from zero.
        start = cyc;
        bus_a.en = 1;
        step(1);
        pulses(0, 1, 2, 2, 4);
        wait_valid(0, start, 80, took);
        check("fresh_latency", took, 65);
        check("fresh_cnt1", int'(bus_a.cnt1), 2);
        bus_a.ack = 1;
        step(1);
        bus_a.ack = 0;
        check("next_busy", int'(bus_a.busy), 1);
        check("next_valid", int'(bus_a.valid), 0);

        // Asynchronous reset mid-window with acc1=3.
        pulses(0, 1, 3, 2, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cnt1", int'(bus_a.cnt1), 0);
        check("arst_valid", int'(bus_a.valid), 0);
        check("arst_busy", int'(bus_a.busy), 0);
        check("arst_ovf1", int'(bus_a.ovf1), 0);
        bus_a.en = 0;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("post_rst_busy", int'(bus_a.busy), 0);
        check("post_rst_valid", int'(bus_a.valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
